// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
// Datapath width is fixed at 32 bits and the destination index at 5 bits.
// The optional branch support is enabled by the ALU_BRANCH_EN macro.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    // Operation select codes understood by the combinational ALU.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SUB  = 4'b0110,
        ALU_PASS = 4'b1000
    } alu_op_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Which comparison the captured SUB result is resolved against.
    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request (decode side) and result (writeback side) handshakes of the issue controller.
// Both channels use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; a producer holds its payload stable while valid is
// high and ready is low.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic            req_funct7_b5;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_imm;
    logic [RW-1:0]   req_rd;

    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic [RW-1:0]   res_rd;
    logic            res_we;
    logic            res_taken;
    logic            res_illegal;

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7_b5,
               req_rs1, req_rs2, req_imm, req_rd, res_ready,
        input  req_ready, res_valid, res_data, res_rd, res_we, res_taken, res_illegal
    );

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7_b5,
               req_rs1, req_rs2, req_imm, req_rd, res_ready,
        output req_ready, res_valid, res_data, res_rd, res_we, res_taken, res_illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of one RV32 integer op into ALU controls and operands.
// Branch opcodes are only recognised when ALU_BRANCH_EN is defined.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output alu_op_e         op,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic            we,
    output br_type_e        br,
    output logic            illegal
);

    // Second source: register for R-type, immediate for I-type.
    logic [XLEN-1:0] src2;
    assign src2 = (opcode == OP_R) ? rs2 : imm;

    // Anything not matched below stays illegal with AND and zero operands.
    always_comb begin
        op      = ALU_AND;
        in1     = '0;
        in2     = '0;
        we      = 1'b0;
        br      = BR_NONE;
        illegal = 1'b1;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    F3_ADD: begin
                        op      = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                        in1     = rs1;
                        in2     = src2;
                        we      = 1'b1;
                        illegal = 1'b0;
                    end
                    F3_SLL: begin
                        // The ALU shifts by all of in2, so the amount is masked here.
                        op      = ALU_SLL;
                        in1     = rs1;
                        in2     = {{(XLEN-5){1'b0}}, src2[4:0]};
                        we      = 1'b1;
                        illegal = 1'b0;
                    end
                    F3_OR, F3_AND: begin
                        op      = (funct3 == F3_OR) ? ALU_OR : ALU_AND;
                        in1     = rs1;
                        in2     = src2;
                        we      = 1'b1;
                        illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_LUI: begin
                op      = ALU_PASS;
                in1     = rs1;
                in2     = imm;
                we      = 1'b1;
                illegal = 1'b0;
            end
`ifdef ALU_BRANCH_EN
            OP_BR: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE ||
                    funct3 == F3_BLT || funct3 == F3_BGE) begin
                    op      = ALU_SUB;
                    in1     = rs1;
                    in2     = rs2;
                    illegal = 1'b0;
                    case (funct3)
                        F3_BEQ:  br = BR_EQ;
                        F3_BNE:  br = BR_NE;
                        F3_BLT:  br = BR_LT;
                        default: br = BR_GE;
                    endcase
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the 32-bit combinational ALU.
// IDLE accepts an op, EXEC lets the ALU see the latched operands and captures its
// result, HOLD offers the result until writeback takes it (and may accept the next op
// in the same cycle). Define ALU_BRANCH_EN to resolve RV32 branch conditions.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_less,
    output issue_state_e    dbg_state
);

    issue_state_e    state;
    alu_op_e         d_op;
    logic [XLEN-1:0] d_in1, d_in2;
    logic            d_we, d_illegal;
    br_type_e        d_br;

    alu_op_e         op_q;
    logic [XLEN-1:0] in1_q, in2_q;
    logic            we_q, ill_q;
    logic [RW-1:0]   rd_q;

    logic            res_valid_q, res_we_q, res_ill_q;
    logic [XLEN-1:0] res_data_q;
    logic [RW-1:0]   res_rd_q;
    logic            accept;

    alu_issue_decode u_decode (
        .opcode    (bus.req_opcode),
        .funct3    (bus.req_funct3),
        .funct7_b5 (bus.req_funct7_b5),
        .rs1       (bus.req_rs1),
        .rs2       (bus.req_rs2),
        .imm       (bus.req_imm),
        .op        (d_op),
        .in1       (d_in1),
        .in2       (d_in2),
        .we        (d_we),
        .br        (d_br),
        .illegal   (d_illegal)
    );

    // Ready in IDLE, or in HOLD in the same cycle the result is consumed.
    assign bus.req_ready = rst_n & ((state == IDLE) | ((state == HOLD) & bus.res_ready));
    assign accept        = bus.req_valid & bus.req_ready;

    // Issue FSM with operand/decode latches and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= ALU_AND;
            in1_q       <= '0;
            in2_q       <= '0;
            we_q        <= 1'b0;
            ill_q       <= 1'b0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_we_q    <= 1'b0;
            res_ill_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= d_op;
                in1_q <= d_in1;
                in2_q <= d_in2;
                we_q  <= d_we;
                ill_q <= d_illegal;
                rd_q  <= bus.req_rd;
            end
            case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= ill_q ? '0 : alu_out;
                    res_rd_q    <= rd_q;
                    res_we_q    <= we_q;
                    res_ill_q   <= ill_q;
                    state       <= HOLD;
                end
                HOLD: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    state       <= accept ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_BRANCH_EN
    br_type_e br_q;
    logic     taken;
    logic     res_taken_q;

    // Branch condition from the captured SUB; zero is derived here, not taken from the ALU.
    always_comb begin
        taken = 1'b0;
        case (br_q)
            BR_EQ:   taken = (alu_out == '0);
            BR_NE:   taken = (alu_out != '0);
            BR_LT:   taken = alu_less;
            BR_GE:   taken = ~alu_less;
            default: taken = 1'b0;
        endcase
    end

    // Branch type latched with the op; outcome captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q        <= BR_NONE;
            res_taken_q <= 1'b0;
        end else begin
            if (accept) br_q <= d_br;
            if (state == EXEC) res_taken_q <= taken;
        end
    end

    assign bus.res_taken = res_taken_q;
`else
    logic unused_branch;
    assign unused_branch = alu_less | (|d_br);
    assign bus.res_taken = 1'b0;
`endif

    assign alu_in1         = in1_q;
    assign alu_in2         = in2_q;
    assign alu_op          = op_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_we      = res_we_q;
    assign bus.res_illegal = res_ill_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_out/alu_less, and each
// op's expected writeback record is computed from operand arithmetic and queued.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [31:0]     alu_in1, alu_in2, alu_out;
    logic [3:0]      alu_op;
    logic            alu_less;
    issue_state_e    dbg_state;
    logic [31:0]     alu_diff;

    int checks   = 0;
    int failures = 0;

    // Expected record: {illegal, taken, we, rd[4:0], data[31:0]}
    logic [39:0] exp_q[$];

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_less  (alu_less),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: shifts by the full in2, less flag is SUB bit 31.
    always_comb begin
        alu_diff = alu_in1 - alu_in2;
        alu_less = alu_diff[31];
        case (alu_op)
            4'b0000: alu_out = alu_in1 & alu_in2;
            4'b0001: alu_out = alu_in1 | alu_in2;
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0011: alu_out = alu_in1 << alu_in2;
            4'b0110: alu_out = alu_diff;
            4'b1000: alu_out = alu_in2;
            default: alu_out = 32'h0;
        endcase
    end

    function automatic logic [39:0] ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic b5, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] im,
                                              input logic [4:0] rd);
        logic [31:0] src, data;
        logic        we, tk, ill;
        src  = (opc == 7'b0110011) ? b : im;
        data = 32'h0;
        we   = 1'b0;
        tk   = 1'b0;
        ill  = 1'b1;
        if ((opc == 7'b0110011 || opc == 7'b0010011) &&
            (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd6 || f3 == 3'd7)) begin
            ill = 1'b0;
            we  = 1'b1;
            case (f3)
                3'd0:    data = (opc == 7'b0110011 && b5) ? a - src : a + src;
                3'd1:    data = a << src[4:0];
                3'd6:    data = a | src;
                default: data = a & src;
            endcase
        end else if (opc == 7'b0110111) begin
            ill  = 1'b0;
            we   = 1'b1;
            data = im;
        end
`ifdef ALU_BRANCH_EN
        else if (opc == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) begin
            ill  = 1'b0;
            data = a - b;
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = data[31];
                default: tk = ~data[31];
            endcase
        end
`endif
        return {ill, tk, we, rd, data};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: present one op and queue its expected record.
    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd);
        bus.req_opcode    = opc;
        bus.req_funct3    = f3;
        bus.req_funct7_b5 = b5;
        bus.req_rs1       = a;
        bus.req_rs2       = b;
        bus.req_imm       = im;
        bus.req_rd        = rd;
        bus.req_valid     = 1'b1;
        exp_q.push_back(ref_model(opc, f3, b5, a, b, im, rd));
    endtask

    // Wait (bounded) for ready, take the accept edge; afterwards the op is in EXEC.
    task automatic accept_op();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("exec_res_valid_low", bus.res_valid, 0);
    endtask

    // Scoreboard: compare the offered result against the oldest expectation.
    task automatic wait_result(output logic [39:0] e);
        check("res_valid", bus.res_valid, 1);
        check("exp_q_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check("res_data", bus.res_data, e[31:0]);
        check("res_rd", bus.res_rd, e[36:32]);
        check("res_we", bus.res_we, e[37]);
        check("res_taken", bus.res_taken, e[38]);
        check("res_illegal", bus.res_illegal, e[39]);
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("res_valid_after_consume", bus.res_valid, 0);
    endtask

    initial begin
        logic [39:0] e;
        logic [6:0]  opc;

        // Reset
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_opcode = '0;
        bus.req_funct3 = '0;
        bus.req_funct7_b5 = 1'b0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_imm = '0;
        bus.req_rd = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_flags", {bus.res_we, bus.res_taken, bus.res_illegal}, 0);
        check("rst_res_rd", bus.res_rd, 0);
        check("rst_alu_regs", {alu_op, alu_in1, alu_in2}, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();
        check("idle_req_ready", bus.req_ready, 1);

        // ADD 5+7 -> rd 3
        drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3);
        accept_op();
        check("add_alu_op", alu_op, 4'b0010);
        tick();
        wait_result(e);
        check("add_data_const", bus.res_data, 32'd12);
        consume();

        // SLL by rs2=0x24 must use only the low five bits
        drive(7'b0110011, 3'b001, 1'b0, 32'd1, 32'h24, 32'd0, 5'd4);
        accept_op();
        check("sll_alu_in2", alu_in2, 32'd4);
        tick();
        wait_result(e);
        check("sll_data_const", bus.res_data, 32'h10);
        consume();

        // SLLI with a negative immediate, SUB, LUI, ORI, ANDI
        drive(7'b0010011, 3'b001, 1'b0, 32'h3, 32'd0, 32'hFFFFFFE3, 5'd5);
        accept_op();
        check("slli_alu_in2", alu_in2, 32'd3);
        tick(); wait_result(e); consume();
        drive(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 5'd6);
        accept_op();
        check("sub_alu_op", alu_op, 4'b0110);
        tick(); wait_result(e); consume();
        drive(7'b0110111, 3'b010, 1'b0, 32'h5, 32'h0, 32'h12345000, 5'd0);
        accept_op();
        check("lui_alu_op", alu_op, 4'b1000);
        tick(); wait_result(e); consume();
        drive(7'b0010011, 3'b110, 1'b1, 32'hF0F0_0000, 32'h0, 32'h0000_0F0F, 5'd8);
        accept_op(); tick(); wait_result(e); consume();
        drive(7'b0010011, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0, 32'hFFFF_0F0F, 5'd9);
        accept_op(); tick(); wait_result(e); consume();

        // Branches
        drive(7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd1);
        accept_op();
`ifdef ALU_BRANCH_EN
        check("blt_alu_op", alu_op, 4'b0110);
        tick(); wait_result(e);
        check("blt_taken_const", bus.res_taken, 1);
        check("blt_we_const", bus.res_we, 0);
`else
        check("blt_off_alu_op", alu_op, 4'b0000);
        tick(); wait_result(e);
        check("blt_off_illegal_const", bus.res_illegal, 1);
`endif
        consume();
        drive(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 5'd2);
        accept_op(); tick(); wait_result(e); consume();
        drive(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'd0, 5'd2);
        accept_op(); tick(); wait_result(e); consume();
        drive(7'b1100011, 3'b101, 1'b0, 32'd3, 32'hFFFFFFF0, 32'd0, 5'd2);
        accept_op(); tick(); wait_result(e); consume();

        // Illegal opcode
        drive(7'b0000000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd1, 5'd11);
        accept_op();
        check("ill_alu_op", alu_op, 4'b0000);
        tick(); wait_result(e);
        check("ill_flag_const", {bus.res_illegal, bus.res_we, bus.res_data}, {1'b1, 1'b0, 32'h0});
        consume();

        // Backpressure for 5 cycles, then back-to-back accept
        drive(7'b0010011, 3'b110, 1'b0, 32'h0F0F0000, 32'h0, 32'h000000FF, 5'd7);
        accept_op(); tick(); wait_result(e);
        drive(7'b0110011, 3'b111, 1'b0, 32'hFFFF00FF, 32'h0F0F0F0F, 32'h0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", bus.res_valid, 1);
            check("bp_data", bus.res_data, e[31:0]);
            check("bp_rd", bus.res_rd, e[36:32]);
            check("bp_req_ready", bus.req_ready, 0);
        end
        bus.res_ready = 1'b1;
        #1;
        check("b2b_req_ready", bus.req_ready, 1);
        tick();
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("b2b_exec_in1", alu_in1, 32'hFFFF00FF);
        check("b2b_valid_drop", bus.res_valid, 0);
        tick(); wait_result(e); consume();

        // Randomized ops with random writeback stalls
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       opc = 7'b0110011;
                1:       opc = 7'b0010011;
                2:       opc = 7'b0110111;
                3:       opc = 7'b1100011;
                default: opc = 7'($urandom);
            endcase
            drive(opc, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
            accept_op();
            tick();
            wait_result(e);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("rnd_hold_data", bus.res_data, e[31:0]);
            end
            consume();
        end

        // Asynchronous reset while a result is held
        drive(7'b0110011, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 5'd12);
        accept_op(); tick(); wait_result(e);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_req_ready", bus.req_ready, 0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", bus.req_ready, 1);
        tick();
        tick();
        check("post_rst_no_stale", {bus.res_valid, bus.res_data}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
